// File: rtl/radix5_pkg.sv
// rtl/radix5_pkg.sv - shared constants and FSM state type for the radix-5 scaling stage
package radix5_pkg;
  localparam int FP_W = 32;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int RADIX = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/fp_exp_scale.sv
// rtl/fp_exp_scale.sv - single-precision scale by 2^-sh via exponent subtraction
// Optional macro SCALE_FLUSH_EN: flush underflowing normals to signed zero.
module fp_exp_scale
  import radix5_pkg::*;
(
  input  logic [FP_W-1:0] operand,
  input  logic [2:0]      sh,
  output logic [FP_W-1:0] result
);
  logic [7:0] e;
  logic [7:0] e_sub;

  assign e     = operand[EXP_HI:EXP_LO];
  assign e_sub = e - {5'd0, sh};

  always_comb begin
    result = operand;
    // zero/denormal and Inf/NaN keep their encoding untouched
    if (e != 8'd0 && e != EXP_MAX) begin
`ifdef SCALE_FLUSH_EN
      if (e <= {5'd0, sh}) begin
        result = {operand[FP_W-1], {(FP_W-1){1'b0}}};
      end else begin
        result[EXP_HI:EXP_LO] = e_sub;
      end
`else
      result[EXP_HI:EXP_LO] = e_sub;
`endif
    end
  end
endmodule

// File: rtl/radix5_scale_ctrl.sv
// rtl/radix5_scale_ctrl.sv - radix-5 frame sequencer with per-frame power-of-two scaling
// Optional macro SCALE_FLUSH_EN (handled inside fp_exp_scale).
module radix5_scale_ctrl
  import radix5_pkg::*;
#(
  parameter int GW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      scale_sh,
  input  logic [GW-1:0]   num_groups,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_re,
  input  logic [FP_W-1:0] in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_re,
  output logic [FP_W-1:0] out_im,
  output logic            out_first,
  output logic            out_last,
  output logic            busy,
  output logic            done
);
  localparam logic [2:0] IDX_LAST = 3'(RADIX - 1);

  state_t          state, state_next;
  logic [2:0]      sh_q;
  logic [GW-1:0]   ng_q;
  logic [2:0]      idx;
  logic [GW-1:0]   grp;
  logic            last_in;
  logic            in_fire;
  logic            out_fire;
  logic            done_next;
  logic            accept_start;
  logic [FP_W-1:0] re_scaled, im_scaled;

  fp_exp_scale u_scale_re (.operand(in_re), .sh(sh_q), .result(re_scaled));
  fp_exp_scale u_scale_im (.operand(in_im), .sh(sh_q), .result(im_scaled));

  assign last_in      = (idx == IDX_LAST) && (grp == ng_q - 1'b1);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign busy         = (state != IDLE);
  assign accept_start = (state == IDLE) && start && (num_groups != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_groups == '0) done_next = 1'b1;
          else                  state_next = RUN;
        end
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_in) state_next = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q      <= '0;
      ng_q      <= '0;
      idx       <= '0;
      grp       <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (accept_start) begin
        sh_q <= scale_sh;
        ng_q <= num_groups;
        idx  <= '0;
        grp  <= '0;
      end
      // a new input always reloads; otherwise a taken output empties the register
      if (in_fire) begin
        out_valid <= 1'b1;
        out_re    <= re_scaled;
        out_im    <= im_scaled;
        out_first <= (idx == 3'd0);
        out_last  <= last_in;
        if (idx == IDX_LAST) begin
          idx <= '0;
          grp <= grp + 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_radix5_scale_ctrl.sv
// tb/tb_radix5_scale_ctrl.sv - directed self-checking bench for radix5_scale_ctrl
module tb_radix5_scale_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  scale_sh = 3'd0;
  logic [7:0]  num_groups = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_re = 32'd0;
  logic [31:0] in_im = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_re, out_im;
  logic        out_first, out_last, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  radix5_scale_ctrl #(.GW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scale_sh(scale_sh), .num_groups(num_groups),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic pulse_start(input logic [2:0] sh, input logic [7:0] ng);
    @(negedge clk);
    start = 1'b1; scale_sh = sh; num_groups = ng;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_re !== 32'd0 || out_im !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", out_re, out_im); end
    n_cmp++; if (out_first !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_markers: got %b%b want 00", out_first, out_last); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got busy=%b done=%b in_ready=%b want 0", busy, done, in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int got = 0;
    int cyc = 0;
    pulse_start(3'd2, 8'd1);
    while (got < 5 && cyc < 100) begin
      out_ready = 1'b1; in_valid = 1'b1; in_re = 32'h3F800000; in_im = 32'hC0000000;
      #1;
      if (out_valid) begin
        n_cmp++; if (out_re !== 32'h3E800000) begin n_fail++; $display("FAIL basic_re[%0d]: got %h want 3e800000", got, out_re); end
        n_cmp++; if (out_im !== 32'hBF000000) begin n_fail++; $display("FAIL basic_im[%0d]: got %h want bf000000", got, out_im); end
        n_cmp++; if (out_first !== (got == 0)) begin n_fail++; $display("FAIL basic_first[%0d]: got %b", got, out_first); end
        n_cmp++; if (out_last !== (got == 4)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b", got, out_last); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL basic_count: got %0d want 5", got); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b want 1/0", done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_boundary;
    logic [31:0] vre [5];
    logic [31:0] vim [5];
    logic [31:0] ere [5];
    logic [31:0] eim [5];
    int got = 0;
    int n_in = 0;
    int cyc = 0;
    vre = '{32'h00800000, 32'h80800000, 32'h01800000, 32'h7F800000, 32'h7FC00000};
    vim = '{32'h00000000, 32'h80000001, 32'h3F800000, 32'hFF800000, 32'h00400000};
    eim = '{32'h00000000, 32'h80000001, 32'h3E800000, 32'hFF800000, 32'h00400000};
`ifdef SCALE_FLUSH_EN
    ere = '{32'h00000000, 32'h80000000, 32'h00800000, 32'h7F800000, 32'h7FC00000};
`else
    ere = '{32'h7F800000, 32'hFF800000, 32'h00800000, 32'h7F800000, 32'h7FC00000};
`endif
    pulse_start(3'd2, 8'd1);
    while (got < 5 && cyc < 100) begin
      out_ready = 1'b1;
      in_valid = (n_in < 5);
      in_re = vre[n_in % 5]; in_im = vim[n_in % 5];
      #1;
      if (out_valid) begin
        n_cmp++; if (out_re !== ere[got]) begin n_fail++; $display("FAIL bound_re[%0d]: got %h want %h", got, out_re, ere[got]); end
        n_cmp++; if (out_im !== eim[got]) begin n_fail++; $display("FAIL bound_im[%0d]: got %h want %h", got, out_im, eim[got]); end
        got++;
      end
      if (in_valid && in_ready) n_in++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 5 || done !== 1'b1) begin n_fail++; $display("FAIL bound_end: got count=%0d done=%b want 5/1", got, done); end
  endtask

  task automatic test_stall;
    int got = 0;
    int n_in = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] h_re = 32'd0;
    logic [31:0] h_im = 32'd0;
    logic [31:0] e_re, e_im;
    logic h_first = 1'b0;
    logic h_last = 1'b0;
    pulse_start(3'd3, 8'd3);
    while (got < 15 && cyc < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (n_in < 15);
      in_re = {1'b0, 8'(100 + n_in), 23'(n_in)};
      in_im = 32'hC0000000 | 32'(n_in);
      #1;
      if (out_valid && prev_stall) begin
        n_cmp++; if (out_re !== h_re || out_im !== h_im || out_first !== h_first || out_last !== h_last)
          begin n_fail++; $display("FAIL stall_hold[%0d]: got %h/%h want %h/%h", got, out_re, out_im, h_re, h_im); end
      end
      if (out_valid && out_ready) begin
        e_re = {1'b0, 8'(97 + got), 23'(got)};
        e_im = 32'hBE800000 | 32'(got);
        n_cmp++; if (out_re !== e_re || out_im !== e_im) begin n_fail++; $display("FAIL stall_data[%0d]: got %h/%h want %h/%h", got, out_re, out_im, e_re, e_im); end
        n_cmp++; if (out_first !== (got % 5 == 0) || out_last !== (got == 14)) begin n_fail++; $display("FAIL stall_markers[%0d]: got %b%b", got, out_first, out_last); end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      h_re = out_re; h_im = out_im; h_first = out_first; h_last = out_last;
      if (in_valid && in_ready) n_in++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 15 || n_in !== 15) begin n_fail++; $display("FAIL stall_count: got out=%0d in=%0d want 15/15", got, n_in); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_extra: got out_valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_start_ignored;
    int got = 0;
    int cyc = 0;
    pulse_start(3'd2, 8'd1);
    while (got < 5 && cyc < 100) begin
      out_ready = 1'b1; in_valid = 1'b1; in_re = 32'h3F800000; in_im = 32'hC0000000;
      start = (cyc == 2); scale_sh = 3'd7; num_groups = 8'd4;
      #1;
      if (out_valid) begin
        n_cmp++; if (out_re !== 32'h3E800000 || out_im !== 32'hBF000000) begin n_fail++; $display("FAIL ign_data[%0d]: got %h/%h want 3e800000/bf000000", got, out_re, out_im); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    n_cmp++; if (got !== 5 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_end: got count=%0d done=%b busy=%b want 5/1/0", got, done, busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_zero_groups;
    pulse_start(3'd1, 8'd0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_reset_mid;
    int n_in = 0;
    int cyc = 0;
    int seen_done = 0;
    pulse_start(3'd0, 8'd2);
    while (n_in < 7 && cyc < 100) begin
      out_ready = 1'b1; in_valid = 1'b1; in_re = 32'h40000000; in_im = 32'h40400000;
      #1;
      if (in_ready) n_in++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (n_in !== 7 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got accepted=%0d busy=%b want 7/1", n_in, busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || out_re !== 32'd0 || out_im !== 32'd0) begin n_fail++; $display("FAIL mid_out: got v=%b %h/%h want 0", out_valid, out_re, out_im); end
    n_cmp++; if (out_first !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got first=%b last=%b busy=%b done=%b want 0", out_first, out_last, busy, done); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", seen_done); end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_stall();
    test_start_ignored();
    test_zero_groups();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
